// File: rtl/note_scheduler.sv
// note_scheduler: walks the song's note ROM in address order and releases each note to the
// on-screen note queue LOOKAHEAD ticks before its hit time. It stops at the end marker
// (an entry with frets == 0) or after the last ROM address.
//
// Optional feature macro: NOTE_SCHED_MISS_DROP_EN
//   When defined, entries whose hit time has already passed are dropped rather than emitted,
//   and they are counted on notes_dropped_o.
//
// Ports:
//   clk_i            100 MHz system clock
//   reset_ni         synchronous, active-low reset
//   start_i          single-cycle pulse; (re)starts the song from ROM address 0
//   song_time_i      current song time in 10 ms ticks
//   rom_addr_o       registered note ROM read address
//   rom_data_i       {hit_time[15:0], frets[FRET_W-1:0]}, valid one cycle after rom_addr_o
//   note_valid_o     note presented to the note queue
//   note_ready_i     note queue accepts the note
//   note_time_o      hit time of the presented note
//   note_frets_o     fret mask of the presented note
//   busy_o           high in every state except idle and done
//   song_done_o      high once the end of the song is reached
//   notes_emitted_o  completed valid/ready transfers since start
//   notes_dropped_o  late entries skipped since start (NOTE_SCHED_MISS_DROP_EN only)
module note_scheduler #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned LOOKAHEAD = 200,
    parameter int unsigned FRET_W    = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic [15:0]            song_time_i,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic [16+FRET_W-1:0]   rom_data_i,
    output logic                   note_valid_o,
    input  logic                   note_ready_i,
    output logic [15:0]            note_time_o,
    output logic [FRET_W-1:0]      note_frets_o,
    output logic                   busy_o,
    output logic                   song_done_o,
`ifdef NOTE_SCHED_MISS_DROP_EN
    output logic [ADDR_W:0]        notes_dropped_o,
`endif
    output logic [ADDR_W:0]        notes_emitted_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StCheck,
        StEmit,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr    = '1;
    localparam logic [ADDR_W-1:0] AddrOne     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [16:0]       Lookahead17 = 17'(LOOKAHEAD);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         time_q, time_d;
    logic [FRET_W-1:0]   frets_q, frets_d;
    logic [ADDR_W:0]     emitted_q, emitted_d;
`ifdef NOTE_SCHED_MISS_DROP_EN
    logic [ADDR_W:0]     dropped_q, dropped_d;
`endif

    // ROM entry fields and the release decision
    logic [15:0]       rom_time;
    logic [FRET_W-1:0] rom_frets;
    logic [16:0]       due_limit;
    logic              is_end;
    logic              is_due;

    assign rom_time  = rom_data_i[16+FRET_W-1:FRET_W];
    assign rom_frets = rom_data_i[FRET_W-1:0];
    // 17-bit sum so a song time near 65535 cannot wrap the release window
    assign due_limit = {1'b0, song_time_i} + Lookahead17;
    assign is_end    = (rom_frets == '0);
    assign is_due    = ({1'b0, rom_time} <= due_limit);

`ifdef NOTE_SCHED_MISS_DROP_EN
    logic is_late;
    assign is_late = ({1'b0, rom_time} < {1'b0, song_time_i});
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        time_d    = time_q;
        frets_d   = frets_q;
        emitted_d = emitted_q;
`ifdef NOTE_SCHED_MISS_DROP_EN
        dropped_d = dropped_q;
`endif
        if (start_i) begin
            // Restart wins over every other transition, even a coincident handshake
            state_d   = StFetch;
            addr_d    = '0;
            emitted_d = '0;
`ifdef NOTE_SCHED_MISS_DROP_EN
            dropped_d = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StFetch: begin
                    state_d = StWait;
                end
                StWait: begin
                    state_d = StCheck;
                end
                StCheck: begin
                    // Recaptured every cycle; the entry is stable while waiting to become due
                    time_d  = rom_time;
                    frets_d = rom_frets;
                    if (is_end) begin
                        state_d = StDone;
`ifdef NOTE_SCHED_MISS_DROP_EN
                    end else if (is_late) begin
                        dropped_d = dropped_q + CntOne;
                        if (addr_q == LastAddr) begin
                            state_d = StDone;
                        end else begin
                            addr_d  = addr_q + AddrOne;
                            state_d = StFetch;
                        end
`endif
                    end else if (is_due) begin
                        state_d = StEmit;
                    end
                end
                StEmit: begin
                    if (note_ready_i) begin
                        emitted_d = emitted_q + CntOne;
                        // No wrap: the last address ends the song
                        if (addr_q == LastAddr) begin
                            state_d = StDone;
                        end else begin
                            addr_d  = addr_q + AddrOne;
                            state_d = StFetch;
                        end
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            time_q    <= '0;
            frets_q   <= '0;
            emitted_q <= '0;
`ifdef NOTE_SCHED_MISS_DROP_EN
            dropped_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            time_q    <= time_d;
            frets_q   <= frets_d;
            emitted_q <= emitted_d;
`ifdef NOTE_SCHED_MISS_DROP_EN
            dropped_q <= dropped_d;
`endif
        end
    end

    assign rom_addr_o      = addr_q;
    assign note_valid_o    = (state_q == StEmit);
    assign note_time_o     = time_q;
    assign note_frets_o    = frets_q;
    assign busy_o          = (state_q != StIdle) && (state_q != StDone);
    assign song_done_o     = (state_q == StDone);
    assign notes_emitted_o = emitted_q;
`ifdef NOTE_SCHED_MISS_DROP_EN
    assign notes_dropped_o = dropped_q;
`endif

endmodule
